// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: host start/result handshake plus datapath drive and sense
// signals for truth_table_sweeper (slave = sweeper side, master = host/datapath side).
interface truth_table_sweeper_if;
  logic        start;
  logic        dut_c;
  logic        X;
  logic        Y;
  logic        Z;
  logic        P;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic [3:0]  fail_idx;
  modport slave (input start, dut_c, output X, Y, Z, P, busy, done, pass, truth_table, fail_idx);
  modport master (output start, dut_c, input X, Y, Z, P, busy, done, pass, truth_table, fail_idx);
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {X,Y,Z,P} vectors, captures C into a truth table and
// compares it with EXPECTED. Define MISMATCH_HALT_EN to stop the sweep at the first mismatch.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hF888
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave s
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, cnt_q, cnt_d, fail_q, fail_d;
  logic        err_q, err_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] table_q, table_d;
  logic        mis;
  assign mis = s.dut_c != EXPECTED[idx_q];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    table_d = table_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: if (s.start) begin
        state_d = DRIVE;
        idx_d   = '0;
        table_d = '0;
        err_d   = 1'b0;
        fail_d  = '0;
        pass_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
      end
      DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = cnt_q == '0 ? SAMPLE : SETTLE;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
      end
      SAMPLE: begin
        table_d[idx_q] = s.dut_c;
        if (mis && !err_q) begin
          fail_d = idx_q;
          err_d  = 1'b1;
        end
`ifdef MISMATCH_HALT_EN
        if (mis || idx_q == 4'd15) begin
`else
        if (idx_q == 4'd15) begin
`endif
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !(err_q || mis);
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      fail_q  <= fail_d;
    end
  // idx_q doubles as the registered vector drive, so {X,Y,Z,P} always equals idx
  assign {s.X, s.Y, s.Z, s.P} = idx_q;
  assign s.busy        = busy_q;
  assign s.done        = done_q;
  assign s.pass        = pass_q;
  assign s.truth_table = table_q;
  assign s.fail_idx    = fail_q;
endmodule
